// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder
//   Memory-side responder for the instruction control unit's fetch handshake.
//   Each accepted mem_send reads one 16-bit word from internal program memory
//   at PC. The word comes back on instr_or_reg with a one-cycle strobe:
//   instr_load for an opcode word, mem_read for an extension word. Opcode words
//   are pre-decoded to count the MSP430-style extension words that follow.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   mem_send       word request (level, sampled each clock, ignored while busy)
//   pc_load        load pc_load_val (bit 0 cleared) and abort any fetch
//   pc_load_val    new PC, byte address
//   wr_en/wr_addr/wr_data  program-load write port (word address)
//   instr_or_reg   returned word, held until the next strobe
//   instr_load     1-cycle strobe, opcode word valid
//   mem_read       1-cycle strobe, extension word valid
//   busy           high in FETCH/PRESENT
//   pc             current PC, byte address
//   ext_pending    extension words still owed for the current instruction
module instr_fetch_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_send,
  input  logic              pc_load,
  input  logic [15:0]       pc_load_val,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic [15:0]       instr_or_reg,
  output logic              instr_load,
  output logic              mem_read,
  output logic              busy,
  output logic [15:0]       pc,
  output logic [1:0]        ext_pending
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_EXT = 2'd1,
    FETCH    = 2'd2,
    PRESENT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        ld_q, ld_d;
  logic        rd_q, rd_d;
  logic [1:0]  ext_q, ext_d;
  logic        from_idle_q, from_idle_d;
  logic        issue;
  logic [15:0] rdata_q;

  logic [15:0] mem [0:(2**ADDR_W)-1];

  // Source operand needs an extension word unless it is a register, an
  // indirect mode, or served by the R2/R3 constant generators.
  function automatic logic srcx(input logic [1:0] as_f, input logic [3:0] reg_f);
    return ((as_f == 2'b01) && (reg_f != 4'd3)) ||
           ((as_f == 2'b11) && (reg_f == 4'd0));
  endfunction

  function automatic logic [1:0] ext_count(input logic [15:0] w);
    logic [1:0] n;
    n = 2'd0;
    if (w[15:12] >= 4'd4)
      n = {1'b0, srcx(w[5:4], w[11:8])} + {1'b0, w[7]};
    else if (w[15:12] == 4'b0001)
      n = {1'b0, srcx(w[5:4], w[3:0])};
    return n;
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    ld_d        = 1'b0;
    rd_d        = 1'b0;
    ext_d       = ext_q;
    from_idle_d = from_idle_q;
    issue       = 1'b0;
    if (pc_load) begin
      pc_d    = pc_load_val & 16'hFFFE;
      state_d = IDLE;
      ext_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, WAIT_EXT: begin
          if (mem_send) begin
            issue       = 1'b1;
            pc_d        = pc_q + 16'd2;
            state_d     = FETCH;
            from_idle_d = (state_q == IDLE);
          end
        end
        FETCH: state_d = PRESENT;
        PRESENT: begin
          instr_d = rdata_q;
          if (from_idle_q) begin
            ld_d  = 1'b1;
            ext_d = ext_count(rdata_q);
          end else begin
            rd_d  = 1'b1;
            ext_d = (ext_q != 2'd0) ? ext_q - 2'd1 : 2'd0;
          end
          // Leave on the updated count so the last extension returns to IDLE.
          state_d = (ext_d != 2'd0) ? WAIT_EXT : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC & 16'hFFFE;
      instr_q     <= '0;
      ld_q        <= 1'b0;
      rd_q        <= 1'b0;
      ext_q       <= '0;
      from_idle_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      ext_q       <= ext_d;
      from_idle_q <= from_idle_d;
    end
  end

  // Program memory: not reset; a same-cycle write leaves the read with old data.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    if (issue)
      rdata_q <= mem[pc_q[ADDR_W:1]];
  end

  assign instr_or_reg = instr_q;
  assign instr_load   = ld_q;
  assign mem_read     = rd_q;
  assign busy         = (state_q == FETCH) || (state_q == PRESENT);
  assign pc           = pc_q;
  assign ext_pending  = ext_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
module tb_instr_fetch_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_send = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = '0;
  logic        wr_en = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [15:0] wr_data = '0;

  logic [15:0] a_instr, b_instr, a_pc, b_pc;
  logic        a_ld, a_rd, a_busy, b_ld, b_rd, b_busy;
  logic [1:0]  a_ext, b_ext;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_responder #(.ADDR_W(8), .RESET_PC(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .mem_send(mem_send), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .wr_en(wr_en), .wr_addr(wr_addr[7:0]),
    .wr_data(wr_data), .instr_or_reg(a_instr), .instr_load(a_ld),
    .mem_read(a_rd), .busy(a_busy), .pc(a_pc), .ext_pending(a_ext)
  );

  instr_fetch_responder #(.ADDR_W(15), .RESET_PC(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .mem_send(mem_send), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .instr_or_reg(b_instr), .instr_load(b_ld),
    .mem_read(b_rd), .busy(b_busy), .pc(b_pc), .ext_pending(b_ext)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [14:0] addr, input logic [15:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One request; returns in the cycle where the strobe should be visible.
  task automatic req();
    mem_send = 1'b1;
    tick();
    mem_send = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // Test 1: reset state and a plain opcode word
    #1;
    tick();
    check("rst_pc", a_pc, 16'h0000);
    check("rst_instr", a_instr, 16'h0000);
    check("rst_strobes", {14'd0, a_ld, a_rd}, 16'h0000);
    check("rst_ext", {14'd0, a_ext}, 16'h0000);
    check("rst_busy", {15'd0, a_busy}, 16'h0000);
    rst = 1'b0;
    write_word(15'd0, 16'h4A0B);
    mem_send = 1'b1;
    tick();
    mem_send = 1'b0;
    check("t1_fetch_busy", {15'd0, a_busy}, 16'h0001);
    check("t1_fetch_nostrobe", {15'd0, a_ld}, 16'h0000);
    tick();
    check("t1_present_nostrobe", {15'd0, a_ld}, 16'h0000);
    tick();
    check("t1_ld", {15'd0, a_ld}, 16'h0001);
    check("t1_instr", a_instr, 16'h4A0B);
    check("t1_ext", {14'd0, a_ext}, 16'h0000);
    check("t1_pc", a_pc, 16'h0002);
    check("t1_idle", {15'd0, a_busy}, 16'h0000);
    tick();
    check("t1_ld_drop", {15'd0, a_ld}, 16'h0000);

    // Test 2: immediate source, one extension word
    do_reset();
    write_word(15'd0, 16'h403F);
    write_word(15'd1, 16'h1234);
    req();
    check("t2_ld", {15'd0, a_ld}, 16'h0001);
    check("t2_instr", a_instr, 16'h403F);
    check("t2_ext1", {14'd0, a_ext}, 16'h0001);
    tick();
    req();
    check("t2_rd", {14'd0, a_ld, a_rd}, 16'h0001);
    check("t2_ext_word", a_instr, 16'h1234);
    check("t2_ext0", {14'd0, a_ext}, 16'h0000);
    check("t2_pc", a_pc, 16'h0004);
    tick();

    // Test 3: absolute source and destination, two extension words
    do_reset();
    write_word(15'd0, 16'h5292);
    write_word(15'd1, 16'h0200);
    write_word(15'd2, 16'h0202);
    req();
    check("t3_op", {14'd0, a_ld, a_rd}, 16'h0002);
    check("t3_ext2", {14'd0, a_ext}, 16'h0002);
    tick();
    req();
    check("t3_x1", {14'd0, a_ld, a_rd}, 16'h0001);
    check("t3_x1_word", a_instr, 16'h0200);
    check("t3_ext1", {14'd0, a_ext}, 16'h0001);
    tick();
    req();
    check("t3_x2", {14'd0, a_ld, a_rd}, 16'h0001);
    check("t3_x2_word", a_instr, 16'h0202);
    check("t3_ext0", {14'd0, a_ext}, 16'h0000);
    tick();

    // Test 4: constant generator, mem_send held high
    do_reset();
    write_word(15'd0, 16'h4322);
    write_word(15'd1, 16'h4A0B);
    mem_send = 1'b1;
    tick(); tick(); tick();
    check("t4_ld1", {15'd0, a_ld}, 16'h0001);
    check("t4_instr1", a_instr, 16'h4322);
    check("t4_ext", {14'd0, a_ext}, 16'h0000);
    check("t4_pc1", a_pc, 16'h0002);
    tick();
    check("t4_gap", {15'd0, a_ld}, 16'h0000);
    check("t4_pc2", a_pc, 16'h0004);
    tick(); tick();
    mem_send = 1'b0;
    check("t4_ld2", {15'd0, a_ld}, 16'h0001);
    check("t4_instr2", a_instr, 16'h4A0B);
    tick();

    // Test 5: pc_load during FETCH aborts the fetch
    write_word(15'd8, 16'hABCD);
    mem_send = 1'b1;
    tick();
    mem_send = 1'b0;
    pc_load = 1'b1; pc_load_val = 16'h0011;
    tick();
    pc_load = 1'b0;
    check("t5_pc", a_pc, 16'h0010);
    check("t5_busy", {15'd0, a_busy}, 16'h0000);
    tick();
    check("t5_nostrobe1", {14'd0, a_ld, a_rd}, 16'h0000);
    tick();
    check("t5_nostrobe2", {14'd0, a_ld, a_rd}, 16'h0000);
    check("t5_held", a_instr, 16'h4A0B);
    req();
    check("t5_ld", {15'd0, a_ld}, 16'h0001);
    check("t5_instr", a_instr, 16'hABCD);
    check("t5_pc_after", a_pc, 16'h0012);
    tick();

    // Test 6a: reset during PRESENT, then during the strobe cycle
    do_reset();
    mem_send = 1'b1;
    tick();
    mem_send = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_busy", {15'd0, a_busy}, 16'h0000);
    check("t6_rst_pc", a_pc, 16'h0000);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6_no_late_strobe", {14'd0, a_ld, a_rd}, 16'h0000);
      tick();
    end
    req();
    check("t6_pre_rst_ld", {15'd0, a_ld}, 16'h0001);
    rst = 1'b1;
    #1;
    check("t6_strobe_cleared", {15'd0, a_ld}, 16'h0000);
    check("t6_instr_cleared", a_instr, 16'h0000);
    tick();
    rst = 1'b0;

    // Test 6b: PC wrap from FFFE with the 15-bit instance
    write_word(15'h7FFF, 16'hBEEF);
    pc_load = 1'b1; pc_load_val = 16'hFFFE;
    tick();
    pc_load = 1'b0;
    check("t6_b_pc_load", b_pc, 16'hFFFE);
    req();
    check("t6_b_ld", {15'd0, b_ld}, 16'h0001);
    check("t6_b_instr", b_instr, 16'hBEEF);
    check("t6_b_wrap", b_pc, 16'h0000);
    check("t6_a_wrap", a_pc, 16'h0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
